// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and the IF stage that
// produces prediction entries.
package branch_resolver_pkg;

  localparam int InstAddrBus = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic                   pred_taken;
    logic [InstAddrBus-1:0] pred_npc;
  } pred_entry_t;

endpackage

// File: rtl/branch_queue.sv
// Generic synchronous circular FIFO with push, pop, clear and a registered full
// flag. Clear wins over a simultaneous push; pop on empty is ignored.
module branch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !clear && ((count != CNT_W'(DEPTH)) || do_pop);
  assign dout    = mem[head];

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      if (clear) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (do_push) tail <= tail + PTR_W'(1);
        if (do_pop)  head <= head + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/branch_resolver.sv
// In-order tracker of predicted control-flow instructions: trains the predictor
// on resolve and flushes/redirects on mispredict. Optional statistics counters
// are enabled by defining BRANCH_RESOLVER_STAT_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_push,
  input  logic [InstAddrBus-1:0] if_pc,
  input  logic                   if_pred_taken,
  input  logic [InstAddrBus-1:0] if_pred_npc,
  input  logic                   ex_resolve,
  input  logic                   ex_taken,
  input  logic [InstAddrBus-1:0] ex_target,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   predict_update,
  output logic [InstAddrBus-1:0] branch_pc,
  output logic [InstAddrBus-1:0] branch_npc,
  output logic                   actual_result,
  output logic                   flush_o,
  output logic [InstAddrBus-1:0] redirect_pc
`ifdef BRANCH_RESOLVER_STAT_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  localparam int EntryW = $bits(pred_entry_t);

  pred_entry_t            push_entry;
  pred_entry_t            head_entry;
  logic [EntryW-1:0]      head_bits;
  logic                   q_empty;
  logic                   pop;
  logic                   mispredict;
  logic                   push_ok;
  logic                   clear;
  logic [InstAddrBus-1:0] correct_pc;

  assign push_entry = '{pc: if_pc, pred_taken: if_pred_taken, pred_npc: if_pred_npc};
  assign head_entry = pred_entry_t'(head_bits);

  assign pop        = ex_resolve && !q_empty;
  assign mispredict = pop && ((head_entry.pred_taken != ex_taken) ||
                              (ex_taken && (head_entry.pred_npc != ex_target)));
  // A pop in the same cycle frees a slot, so a full queue still accepts a push.
  assign push_ok    = if_push && (!full_o || pop) && !mispredict && !flush_i;
  assign clear      = mispredict || flush_i;
  assign correct_pc = ex_taken ? ex_target : head_entry.pc + 32'd4;

  branch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .clear (clear),
    .din   (push_entry),
    .dout  (head_bits),
    .full  (full_o),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      predict_update <= False;
      flush_o        <= False;
      actual_result  <= False;
      branch_pc      <= '0;
      branch_npc     <= '0;
      redirect_pc    <= '0;
    end else begin
      predict_update <= pop;
      flush_o        <= mispredict;
      if (pop) begin
        branch_pc     <= head_entry.pc;
        branch_npc    <= ex_target;
        actual_result <= ex_taken;
      end
      if (mispredict) redirect_pc <= correct_pc;
    end
  end

`ifdef BRANCH_RESOLVER_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop)        stat_branches    <= sat_inc(stat_branches);
      if (mispredict) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_push = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken = 1'b0;
  logic [31:0] if_pred_npc = '0;
  logic        ex_resolve = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        flush_i = 1'b0;
  logic        full_o;
  logic        predict_update;
  logic [31:0] branch_pc;
  logic [31:0] branch_npc;
  logic        actual_result;
  logic        flush_o;
  logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVER_STAT_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_push        (if_push),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_npc    (if_pred_npc),
    .ex_resolve     (ex_resolve),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .flush_i        (flush_i),
    .full_o         (full_o),
    .predict_update (predict_update),
    .branch_pc      (branch_pc),
    .branch_npc     (branch_npc),
    .actual_result  (actual_result),
    .flush_o        (flush_o),
    .redirect_pc    (redirect_pc)
`ifdef BRANCH_RESOLVER_STAT_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an in-order list of outstanding predictions.
  pred_entry_t mq[$];
  logic        exp_pu, exp_flush, exp_ar, exp_full;
  logic [31:0] exp_bpc, exp_bnpc, exp_redirect;
  logic [31:0] exp_nbr, exp_nmis;

  task automatic model_step();
    pred_entry_t e;
    bit popped, wrong, room;
    if (rst) begin
      mq.delete();
      exp_pu = 0; exp_flush = 0; exp_ar = 0; exp_full = 0;
      exp_bpc = 0; exp_bnpc = 0; exp_redirect = 0; exp_nbr = 0; exp_nmis = 0;
      return;
    end
    popped = ex_resolve && (mq.size() > 0);
    wrong = 0;
    room = (mq.size() < DEPTH) || popped;
    if (popped) begin
      e = mq.pop_front();
      exp_bpc = e.pc; exp_bnpc = ex_target; exp_ar = ex_taken;
      wrong = (e.pred_taken != ex_taken) || (ex_taken && e.pred_npc != ex_target);
      if (wrong) exp_redirect = ex_taken ? ex_target : e.pc + 32'd4;
      if (exp_nbr != 32'hFFFF_FFFF) exp_nbr++;
      if (wrong && exp_nmis != 32'hFFFF_FFFF) exp_nmis++;
    end
    exp_pu = popped;
    exp_flush = wrong;
    if (wrong || flush_i) mq.delete();
    if (if_push && room && !wrong && !flush_i)
      mq.push_back('{pc: if_pc, pred_taken: if_pred_taken, pred_npc: if_pred_npc});
    exp_full = (mq.size() == DEPTH);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_push = 0; ex_resolve = 0; flush_i = 0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic pt, input logic [31:0] npc);
    if_push = 1; if_pc = pc; if_pred_taken = pt; if_pred_npc = npc;
    tick();
    if_push = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    total_cnt++; if (full_o !== 1'b0) $display("FAIL reset_full: got %0b want 0", full_o); else pass_cnt++;
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL reset_update: got %0b want 0", predict_update); else pass_cnt++;
    total_cnt++; if (flush_o !== 1'b0) $display("FAIL reset_flush: got %0b want 0", flush_o); else pass_cnt++;
    total_cnt++; if (branch_pc !== 32'h0) $display("FAIL reset_bpc: got %h want 0", branch_pc); else pass_cnt++;
    total_cnt++; if (branch_npc !== 32'h0) $display("FAIL reset_bnpc: got %h want 0", branch_npc); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect: got %h want 0", redirect_pc); else pass_cnt++;
    total_cnt++; if (actual_result !== 1'b0) $display("FAIL reset_ar: got %0b want 0", actual_result); else pass_cnt++;
    rst = 0;
  endtask

  task automatic test_correct_predict();
    push_one(32'h100, 1'b1, 32'h200);
    ex_resolve = 1; ex_taken = 1; ex_target = 32'h200;
    tick();
    ex_resolve = 0;
    total_cnt++; if (predict_update !== 1'b1) $display("FAIL cp_update: got %0b want 1", predict_update); else pass_cnt++;
    total_cnt++; if (branch_pc !== 32'h100) $display("FAIL cp_bpc: got %h want 100", branch_pc); else pass_cnt++;
    total_cnt++; if (branch_npc !== 32'h200) $display("FAIL cp_bnpc: got %h want 200", branch_npc); else pass_cnt++;
    total_cnt++; if (actual_result !== 1'b1) $display("FAIL cp_ar: got %0b want 1", actual_result); else pass_cnt++;
    total_cnt++; if (flush_o !== 1'b0) $display("FAIL cp_flush: got %0b want 0", flush_o); else pass_cnt++;
    tick();
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL cp_pulse_len: got %0b want 0", predict_update); else pass_cnt++;
  endtask

  task automatic test_mispredict_taken();
    push_one(32'h40, 1'b0, 32'h44);
    ex_resolve = 1; ex_taken = 1; ex_target = 32'h80;
    tick();
    total_cnt++; if (flush_o !== 1'b1) $display("FAIL mt_flush: got %0b want 1", flush_o); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h80) $display("FAIL mt_redirect: got %h want 80", redirect_pc); else pass_cnt++;
    total_cnt++; if (predict_update !== 1'b1) $display("FAIL mt_update: got %0b want 1", predict_update); else pass_cnt++;
    tick();
    ex_resolve = 0;
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL mt_empty_resolve: got %0b want 0", predict_update); else pass_cnt++;
    total_cnt++; if (flush_o !== 1'b0) $display("FAIL mt_flush_len: got %0b want 0", flush_o); else pass_cnt++;
  endtask

  task automatic test_mispredict_not_taken();
    push_one(32'h40, 1'b1, 32'h80);
    ex_resolve = 1; ex_taken = 0; ex_target = 32'h0;
    tick();
    ex_resolve = 0;
    total_cnt++; if (flush_o !== 1'b1) $display("FAIL mn_flush: got %0b want 1", flush_o); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h44) $display("FAIL mn_redirect: got %h want 44", redirect_pc); else pass_cnt++;
    total_cnt++; if (actual_result !== 1'b0) $display("FAIL mn_ar: got %0b want 0", actual_result); else pass_cnt++;
  endtask

  task automatic test_full_back_to_back();
    for (int i = 1; i <= 4; i++) push_one(32'(i * 16), 1'b0, 32'(i * 16 + 4));
    total_cnt++; if (full_o !== 1'b1) $display("FAIL full_set: got %0b want 1", full_o); else pass_cnt++;
    push_one(32'hDEAD0, 1'b0, 32'hDEAD4);
    total_cnt++; if (full_o !== 1'b1) $display("FAIL full_drop: got %0b want 1", full_o); else pass_cnt++;
    if_push = 1; if_pc = 32'h50; if_pred_taken = 0; if_pred_npc = 32'h54;
    ex_resolve = 1; ex_taken = 0; ex_target = 32'h0;
    tick();
    if_push = 0;
    total_cnt++; if (full_o !== 1'b1) $display("FAIL full_hold: got %0b want 1", full_o); else pass_cnt++;
    total_cnt++; if (branch_pc !== 32'h10) $display("FAIL full_order0: got %h want 10", branch_pc); else pass_cnt++;
    for (int i = 2; i <= 5; i++) begin
      tick();
      total_cnt++;
      if (predict_update !== 1'b1 || branch_pc !== 32'(i * 16) || flush_o !== 1'b0)
        $display("FAIL full_order%0d: got upd=%0b pc=%h flush=%0b want upd=1 pc=%h flush=0",
                 i, predict_update, branch_pc, flush_o, 32'(i * 16));
      else pass_cnt++;
    end
    ex_resolve = 0;
    tick();
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL full_drained: got %0b want 0", predict_update); else pass_cnt++;
    total_cnt++; if (full_o !== 1'b0) $display("FAIL full_clear: got %0b want 0", full_o); else pass_cnt++;
  endtask

  task automatic test_mispredict_with_push();
    for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(i * 4), 1'b1, 32'h400);
    if_push = 1; if_pc = 32'h999; if_pred_taken = 0; if_pred_npc = 32'h99D;
    ex_resolve = 1; ex_taken = 0;
    tick();
    if_push = 0;
    total_cnt++; if (flush_o !== 1'b1) $display("FAIL mp_flush: got %0b want 1", flush_o); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h304) $display("FAIL mp_redirect: got %h want 304", redirect_pc); else pass_cnt++;
    tick();
    ex_resolve = 0;
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL mp_empty: got %0b want 0", predict_update); else pass_cnt++;
    total_cnt++; if (flush_o !== 1'b0) $display("FAIL mp_noflush: got %0b want 0", flush_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    push_one(32'h500, 1'b1, 32'h600);
    push_one(32'h504, 1'b0, 32'h508);
    rst = 1; ex_resolve = 1; ex_taken = 0; ex_target = 32'h0;
    tick();
    rst = 0;
    total_cnt++;
    if (predict_update !== 0 || flush_o !== 0 || full_o !== 0 || actual_result !== 0 ||
        branch_pc !== 0 || branch_npc !== 0 || redirect_pc !== 0)
      $display("FAIL rstmid_outputs: got upd=%0b fl=%0b full=%0b ar=%0b bpc=%h bnpc=%h rd=%h want all 0",
               predict_update, flush_o, full_o, actual_result, branch_pc, branch_npc, redirect_pc);
    else pass_cnt++;
`ifdef BRANCH_RESOLVER_STAT_EN
    total_cnt++;
    if (stat_branches !== 0 || stat_mispredicts !== 0)
      $display("FAIL rstmid_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    else pass_cnt++;
`endif
    tick();
    ex_resolve = 0;
    total_cnt++; if (predict_update !== 1'b0) $display("FAIL rstmid_empty: got %0b want 0", predict_update); else pass_cnt++;
  endtask

  task automatic test_random();
    rst = 1; idle(); tick(); rst = 0;
    for (int n = 0; n < 800; n++) begin
      if_push = ($urandom_range(0, 9) < 6);
      if_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      if_pred_taken = $urandom_range(0, 1);
      if_pred_npc = if_pred_taken ? {$urandom_range(0, 32'h3FFF), 2'b00} : if_pc + 4;
      ex_resolve = ($urandom_range(0, 9) < 5);
      flush_i = ($urandom_range(0, 49) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        ex_taken = mq[0].pred_taken;
        ex_target = mq[0].pred_taken ? mq[0].pred_npc : {$urandom_range(0, 32'h3FFF), 2'b00};
      end else begin
        ex_taken = $urandom_range(0, 1);
        ex_target = (mq.size() > 0 && $urandom_range(0, 1)) ? mq[0].pred_npc
                                                            : {$urandom_range(0, 32'h3FFF), 2'b00};
      end
      tick();
      total_cnt++;
      if (predict_update !== exp_pu || flush_o !== exp_flush || full_o !== exp_full)
        $display("FAIL rnd_ctrl@%0d: got upd=%0b fl=%0b full=%0b want %0b %0b %0b",
                 n, predict_update, flush_o, full_o, exp_pu, exp_flush, exp_full);
      else pass_cnt++;
      if (exp_pu) begin
        total_cnt++;
        if (branch_pc !== exp_bpc || branch_npc !== exp_bnpc || actual_result !== exp_ar)
          $display("FAIL rnd_train@%0d: got %h %h %0b want %h %h %0b",
                   n, branch_pc, branch_npc, actual_result, exp_bpc, exp_bnpc, exp_ar);
        else pass_cnt++;
      end
      if (exp_flush) begin
        total_cnt++;
        if (redirect_pc !== exp_redirect)
          $display("FAIL rnd_redirect@%0d: got %h want %h", n, redirect_pc, exp_redirect);
        else pass_cnt++;
      end
`ifdef BRANCH_RESOLVER_STAT_EN
      total_cnt++;
      if (stat_branches !== exp_nbr || stat_mispredicts !== exp_nmis)
        $display("FAIL rnd_stats@%0d: got %0d %0d want %0d %0d",
                 n, stat_branches, stat_mispredicts, exp_nbr, exp_nmis);
      else pass_cnt++;
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_full_back_to_back();
    test_mispredict_with_push();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
